// File: rtl/synapse_driver.sv
// synapse_driver
// Serializes one presynaptic spike vector per timestep into a per-channel
// stream of synaptic weights for the downstream accumulator. A spiking
// channel emits its stored weight, a silent channel emits 0. The en output
// pulses together with the last channel of each frame so the accumulator
// closes exactly one frame's sum.
//
// state | meaning
// IDLE  | waiting for a frame; syn_out/en held at 0
// SCAN  | emitting channel idx of the captured frame, one per cycle
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   spike_vec    presynaptic spikes, bit i = channel i
//   spike_valid  spike_vec valid
//   spike_ready  frame can be accepted this cycle (IDLE or last SCAN cycle)
//   w_we/w_addr/w_data  weight write port; out-of-range addresses ignored
//   syn_out      registered per-channel contribution
//   en           frame close, high with the last channel
//   busy         frame in progress
module synapse_driver #(
  parameter int N_INPUTS = 4,
  parameter int W        = 11,
  parameter int AW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] spike_vec,
  input  logic                spike_valid,
  output logic                spike_ready,
  input  logic                w_we,
  input  logic [AW-1:0]       w_addr,
  input  logic [W-1:0]        w_data,
  output logic [W-1:0]        syn_out,
  output logic                en,
  output logic                busy
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx;
  logic [N_INPUTS-1:0] frame;
  logic [W-1:0]        weights [N_INPUTS];
  logic                last;
  logic                scanning;
  logic                accept;
  logic                w_hit;
  logic [31:0]         w_addr_ext;

  assign scanning   = (state == SCAN);
  assign last       = (idx == IW'(N_INPUTS - 1));
  assign accept     = spike_valid && spike_ready;
  assign w_addr_ext = 32'(w_addr);
  assign w_hit      = w_we && (w_addr_ext < 32'(N_INPUTS));

  always_comb begin
    state_nxt   = state;
    spike_ready = 1'b0;
    case (state)
      IDLE: begin
        spike_ready = 1'b1;
        if (accept) state_nxt = SCAN;
      end
      SCAN: begin
        // Opening the handshake on the last channel lets frames abut with
        // no gap cycle.
        spike_ready = last;
        if (last && !accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      frame   <= '0;
      syn_out <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) weights[i] <= '0;
    end else begin
      state <= state_nxt;

      // The output below reads the pre-write weight, so a write to the
      // channel being emitted only shows up in the next frame.
      if (w_hit) weights[w_addr[IW-1:0]] <= w_data;

      if (accept) begin
        frame <= spike_vec;
        idx   <= '0;
      end else if (scanning) begin
        idx <= idx + 1'b1;
      end

      if (scanning) begin
        syn_out <= frame[idx] ? weights[idx] : '0;
        en      <= last;
      end else begin
        syn_out <= '0;
        en      <= 1'b0;
      end

      busy <= accept || scanning;
    end
  end

endmodule

// File: tb/tb_synapse_driver.sv
module tb_synapse_driver;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  spike_vec = '0;
  logic          spike_valid = 1'b0;
  logic          spike_ready;
  logic          w_we = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_data = '0;
  logic [W-1:0]  syn_out;
  logic          en;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  synapse_driver #(.N_INPUTS(N), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .spike_vec(spike_vec), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .syn_out(syn_out), .en(en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: m_pos is the channel being emitted next (-1 = none).
  int           m_pos = -1;
  logic [N-1:0] m_frame = '0;
  int           m_w [N];
  int           exp_syn = 0;
  int           exp_en = 0;
  int           exp_busy = 0;
  bit           model_ok = 0;

  always @(posedge clk) begin
    bit m_ready, take;
    if (rst) begin
      m_pos = -1;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      exp_syn = 0; exp_en = 0; exp_busy = 0;
      model_ok = 1;
    end else begin
      m_ready = (m_pos < 0) || (m_pos == N - 1);
      take    = spike_valid && m_ready;
      if (m_pos >= 0) begin
        exp_syn = m_frame[m_pos] ? m_w[m_pos] : 0;
        exp_en  = (m_pos == N - 1) ? 1 : 0;
      end else begin
        exp_syn = 0; exp_en = 0;
      end
      exp_busy = ((m_pos >= 0) || take) ? 1 : 0;
      if (w_we && int'(w_addr) < N) m_w[w_addr] = int'(w_data);
      if (take) begin
        m_frame = spike_vec;
        m_pos   = 0;
      end else if (m_pos == N - 1) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
    end
  end

  // Downstream accumulator: captures the frame sum when en is seen.
  int acc = 0;
  int captured = -1;
  always @(posedge clk) begin
    if (rst) begin
      acc = 0;
    end else if (en === 1'b1) begin
      captured = acc + int'(syn_out);
      acc = 0;
    end else begin
      acc += int'(syn_out);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("syn_out", int'(syn_out), exp_syn);
      check("en", int'(en), exp_en);
      check("busy", int'(busy), exp_busy);
      check("spike_ready", int'(spike_ready), ((m_pos < 0) || (m_pos == N - 1)) ? 1 : 0);
    end
  end

  task automatic wr(int a, int d);
    w_we = 1'b1; w_addr = AW'(a); w_data = W'(d);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  int seq3 [8] = '{3, 2, 5, 1, 3, 0, 0, 0};
  int seq4 [8] = '{3, 2, 7, 1, 3, 2, 7, 9};
  int seq2 [4] = '{3, 2, 0, 1};

  initial begin
    // 1: reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_syn", int'(syn_out), 0);
      check("idle_ready", int'(spike_ready), 1);
      check("idle_busy", int'(busy), 0);
    end

    // 2: single frame
    wr(0, 3); wr(1, 2); wr(2, 5); wr(3, 1);
    spike_valid = 1'b1; spike_vec = 4'b1011;
    @(negedge clk);
    spike_valid = 1'b0;
    check("t2_busy_at_accept", int'(busy), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t2_syn", int'(syn_out), seq2[k-1]);
      check("t2_en", int'(en), (k == 4) ? 1 : 0);
    end
    repeat (2) @(negedge clk);
    check("t2_acc_sum", captured, 6);

    // 3: back-to-back, spike_vec changes while not ready are ignored
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_vec = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) spike_valid = 1'b0;
      check("t3_syn", int'(syn_out), seq3[k-1]);
      check("t3_en", int'(en), (k == 4 || k == 8) ? 1 : 0);
      check("t3_ready", int'(spike_ready), (k == 3 || k >= 7) ? 1 : 0);
    end

    // 4: mid-frame weight writes
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin w_we = 1'b1; w_addr = 3'd2; w_data = 11'd7; end
      if (k == 3) begin
        w_we = 1'b1; w_addr = 3'd3; w_data = 11'd9;
        spike_valid = 1'b1; spike_vec = 4'b1111;
      end
      @(negedge clk);
      w_we = 1'b0; spike_valid = 1'b0;
    end
    // outputs already compared every cycle by the model; pin the tail here
    check("t4_last_syn", int'(syn_out), 0);
    // re-run and pin literal outputs against the expected sequence
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t4_syn", int'(syn_out), seq4[k+3]);
    end

    // 5: reset mid-frame
    @(negedge clk);
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; spike_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; spike_valid = 1'b0;
    check("t5_syn_after_rst", int'(syn_out), 0);
    check("t5_en_after_rst", int'(en), 0);
    check("t5_busy_after_rst", int'(busy), 0);
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t5_cleared_syn", int'(syn_out), 0);
      check("t5_en", int'(en), (k == 4) ? 1 : 0);
    end

    // 6: zero frame and ignored address
    wr(3, 5);
    spike_valid = 1'b1; spike_vec = 4'b0000;
    @(negedge clk);
    spike_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t6_zero_syn", int'(syn_out), 0);
      check("t6_zero_en", int'(en), (k == 4) ? 1 : 0);
    end
    wr(5, 100);
    spike_valid = 1'b1; spike_vec = 4'b1111;
    @(negedge clk);
    spike_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t6_addr_syn", int'(syn_out), (k == 4) ? 5 : 0);
    end

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      spike_valid = ($urandom_range(0, 3) != 0);
      spike_vec   = N'($urandom_range(0, 15));
      w_we        = ($urandom_range(0, 3) == 0);
      w_addr      = AW'($urandom_range(0, 7));
      w_data      = W'($urandom_range(0, 2047));
    end
    @(negedge clk);
    rst = 1'b0; spike_valid = 1'b0; w_we = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
